vram_row_fetch: RTL

//  Fetches one display row of 15-bit PSX pixels from VRAM and expands each pixel to 24-bit RGB.

---
 rtl/gpu_disp_pkg.sv | 25 ++
 rtl/vram_row_fetch_if.sv | 20 ++
 rtl/vram_row_fetch_req_sync.sv | 26 ++
 rtl/vram_row_fetch.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/gpu_disp_pkg.sv
// Shared display-path types and helpers: fetch FSM states, screen geometry
// and the 15-bit to 24-bit colour expansion used by the row fetcher.
package gpu_disp_pkg;

  localparam int SCREEN_W  = 640;
  localparam int VRAM_LINE = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Replicate the top bits into the low bits so full scale maps to 8'hFF
  function automatic logic [23:0] rgb555_to_888(input logic [14:0] px);
    logic [4:0] r5;
    logic [4:0] g5;
    logic [4:0] b5;
    r5 = px[4:0];
    g5 = px[9:5];
    b5 = px[14:10];
    return {b5, b5[4:2], g5, g5[4:2], r5, r5[4:2]};
  endfunction

endpackage

// File: rtl/vram_row_fetch_if.sv
// VRAM read port: request/grant on the way out, in-order data returns back.
interface vram_row_fetch_if #(
  parameter int AW = 19
);
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [15:0]   mem_rdata;

  modport master (
    output mem_re, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_re, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vram_row_fetch_req_sync.sv
// Brings the scan-out row request into this clock domain and turns its
// rising edge into a single-cycle event.
module vram_row_fetch_req_sync (
  input  logic clk_33MHz,
  input  logic rst_n,
  input  logic req_in,
  output logic req_evt
);

  logic [1:0] sync_reg;
  logic       level_dly_reg;

  // Two-flop synchronizer followed by one delay stage for edge detection
  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg      <= 2'b00;
      level_dly_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], req_in};
      level_dly_reg <= sync_reg[1];
    end
  end

  assign req_evt = sync_reg[1] & ~level_dly_reg;

endmodule

// File: rtl/vram_row_fetch.sv
// Fetches one display row of 15-bit pixels from VRAM, expands them to 24-bit
// RGB and streams them into the scan-out row buffer. Keeps at most MAX_OUTST
// reads in flight and queues one further row request while busy.
module vram_row_fetch
  import gpu_disp_pkg::*;
#(
  parameter int ROW_W     = SCREEN_W,
  parameter int VRAM_XW   = $clog2(VRAM_LINE),
  parameter int VRAM_AW   = 19,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk_33MHz,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       row_req,
  input  logic [VRAM_AW-VRAM_XW-1:0] row_y,
  input  logic [VRAM_XW-1:0]         x_tl,
  vram_row_fetch_if.master           mem,
  output logic                       row_we,
  output logic [$clog2(ROW_W)-1:0]   row_x,
  output logic [23:0]                row_data,
  output logic                       busy,
  output logic                       overrun
);

  localparam int CNT_W = $clog2(ROW_W) + 1;
  localparam int RXW   = $clog2(ROW_W);
  localparam int YW    = VRAM_AW - VRAM_XW;
  localparam logic [CNT_W-1:0] ROW_CNT = CNT_W'(ROW_W);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTST);

  fetch_state_t       state_reg, state_next;
  logic [CNT_W-1:0]   issued_reg, returned_reg;
  logic [YW-1:0]      y_lat_reg, pend_y_reg;
  logic [VRAM_XW-1:0] x_lat_reg, pend_x_reg;
  logic               pend_reg, overrun_reg;
  logic               row_we_reg;
  logic [RXW-1:0]     row_x_reg;
  logic [23:0]        row_data_reg;

  logic               req_evt, req_ok;
  logic               load_req, load_pend;
  logic               can_issue, ret_take;
  logic [CNT_W-1:0]   in_flight;

  vram_row_fetch_req_sync u_req_sync (
    .clk_33MHz (clk_33MHz),
    .rst_n     (rst_n),
    .req_in    (row_req),
    .req_evt   (req_evt)
  );

  assign req_ok    = req_evt & enable;
  assign in_flight = issued_reg - returned_reg;
  assign can_issue = (state_reg == ISSUE) && (issued_reg < ROW_CNT) && (in_flight < OUT_MAX);
  assign ret_take  = mem.mem_rvalid && (state_reg != IDLE);

  assign mem.mem_re   = can_issue;
  assign mem.mem_addr = can_issue ? {y_lat_reg, x_lat_reg + issued_reg[VRAM_XW-1:0]} : '0;

  assign busy     = (state_reg != IDLE);
  assign overrun  = overrun_reg;
  assign row_we   = row_we_reg;
  assign row_x    = row_x_reg;
  assign row_data = row_data_reg;

  // State register
  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state; a request arriving as a row finishes wins over the pending one
  always_comb begin
    state_next = state_reg;
    load_req   = 1'b0;
    load_pend  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_ok) begin
          state_next = ISSUE;
          load_req   = 1'b1;
        end
      end
      ISSUE: begin
        if (issued_reg == ROW_CNT) state_next = DRAIN;
      end
      DRAIN: begin
        if (returned_reg == ROW_CNT) begin
          if (req_ok) begin
            state_next = ISSUE;
            load_req   = 1'b1;
          end else if (pend_reg) begin
            state_next = ISSUE;
            load_pend  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One-deep pending slot; losing a queued request flags overrun
  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg    <= 1'b0;
      pend_y_reg  <= '0;
      pend_x_reg  <= '0;
      overrun_reg <= 1'b0;
    end else if (req_ok && busy && !load_req) begin
      pend_reg   <= 1'b1;
      pend_y_reg <= row_y;
      pend_x_reg <= x_tl;
      if (pend_reg) overrun_reg <= 1'b1;
    end else if (load_pend) begin
      pend_reg <= 1'b0;
    end else if (load_req && pend_reg) begin
      pend_reg    <= 1'b0;
      overrun_reg <= 1'b1;
    end
  end

  // Row origin latches and issue/return counters
  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) begin
      y_lat_reg    <= '0;
      x_lat_reg    <= '0;
      issued_reg   <= '0;
      returned_reg <= '0;
    end else if (load_req) begin
      y_lat_reg    <= row_y;
      x_lat_reg    <= x_tl;
      issued_reg   <= '0;
      returned_reg <= '0;
    end else if (load_pend) begin
      y_lat_reg    <= pend_y_reg;
      x_lat_reg    <= pend_x_reg;
      issued_reg   <= '0;
      returned_reg <= '0;
    end else begin
      if (mem.mem_re && mem.mem_gnt) issued_reg <= issued_reg + 1'b1;
      if (ret_take)                  returned_reg <= returned_reg + 1'b1;
    end
  end

  // Row buffer write port, one cycle behind each accepted return
  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) begin
      row_we_reg   <= 1'b0;
      row_x_reg    <= '0;
      row_data_reg <= '0;
    end else begin
      row_we_reg <= ret_take;
      if (ret_take) begin
        row_x_reg    <= returned_reg[RXW-1:0];
        row_data_reg <= rgb555_to_888(mem.mem_rdata[14:0]);
      end
    end
  end

endmodule
